// File: rtl/nco_xy_serializer_if.sv
// nco_xy_serializer_if
//   Bundles the core-side sample handshake, the external frame strobe and the
//   serialized output lanes of nco_xy_serializer.
//   master : drives samples/rdy/underrun_clr (NCO core + pad-side environment)
//   slave  : the serializer itself
//   Signals: smp_x/smp_y/smp_is/smp_vld/smp_rdy  sample handshake
//            rdy                                 frame request strobe
//            x_out/y_out/is_out/busy             serialized frame
//            underrun/underrun_clr               sticky empty-FIFO flag
interface nco_xy_serializer_if #(
    parameter int DW = 12,
    parameter int CW = 2
);
    logic [DW-1:0] smp_x;
    logic [DW-1:0] smp_y;
    logic          smp_is;
    logic          smp_vld;
    logic          smp_rdy;
    logic          rdy;
    logic [CW-1:0] x_out;
    logic [CW-1:0] y_out;
    logic          is_out;
    logic          busy;
    logic          underrun;
    logic          underrun_clr;

    modport master (
        output smp_x, smp_y, smp_is, smp_vld, rdy, underrun_clr,
        input  smp_rdy, x_out, y_out, is_out, busy, underrun
    );

    modport slave (
        input  smp_x, smp_y, smp_is, smp_vld, rdy, underrun_clr,
        output smp_rdy, x_out, y_out, is_out, busy, underrun
    );
endinterface

// File: rtl/nco_xy_serializer.sv
// nco_xy_serializer
//   Core-side transmitter for the NCO output port. X/Y sample pairs plus a
//   sign flag enter a small FIFO; on each rdy strobe seen in IDLE one frame
//   is sent CW bits per axis per cycle, LSB chunk first, followed by one
//   TAIL cycle. An empty FIFO at frame start repeats the last frame and sets
//   the sticky underrun flag.
//   Ports: clk, rst (async, active high), bus (nco_xy_serializer_if.slave).
module nco_xy_serializer #(
    parameter int DW    = 12,
    parameter int CW    = 2,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    nco_xy_serializer_if.slave   bus
);
    localparam int NCH  = DW / CW;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WW   = 2 * DW + 1;

    typedef enum logic [1:0] {IDLE, SEND, TAIL} state_t;

    state_t          state, state_nxt;
    logic            load;

    // FIFO word layout: {is, y, x}
    logic [WW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [AW:0]     count, count_nxt;
    logic            rdy_q;
    logic            push, pop, empty;

    logic [WW-1:0]   held;
    logic [WW-1:0]   frame;
    logic [DW-1:0]   sx, sy;
    logic [CNTW-1:0] cnt;
    logic            is_q;
    logic            unr_q;

    assign empty = (count == '0);
    assign push  = bus.smp_vld & rdy_q;
    assign pop   = load & ~empty;
    // Occupancy after this edge; smp_rdy is registered from it so a pop at
    // edge e on a full FIFO raises smp_rdy at that same edge.
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    // Frame source uses pre-push FIFO state: a sample arriving on the load
    // edge waits for the next frame.
    assign frame = empty ? held : mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: if (bus.rdy) begin
                load      = 1'b1;
                state_nxt = SEND;
            end
            SEND: if (cnt == CNTW'(NCH - 1)) state_nxt = TAIL;
            TAIL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            rdy_q <= 1'b1;
            held  <= '0;
            sx    <= '0;
            sy    <= '0;
            cnt   <= '0;
            is_q  <= 1'b0;
            unr_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wp] <= {bus.smp_is, bus.smp_y, bus.smp_x};
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count <= count_nxt;
            rdy_q <= (count_nxt != (AW+1)'(DEPTH));

            if (load) begin
                held <= frame;
                sx   <= frame[DW-1:0];
                sy   <= frame[2*DW-1:DW];
                is_q <= frame[WW-1];
                cnt  <= '0;
            end else if (state == SEND) begin
                sx  <= sx >> CW;
                sy  <= sy >> CW;
                cnt <= cnt + 1'b1;
            end

            // Set beats a same-edge clear.
            if (load && empty)         unr_q <= 1'b1;
            else if (bus.underrun_clr) unr_q <= 1'b0;
        end
    end

    assign bus.smp_rdy  = rdy_q;
    assign bus.x_out    = (state == SEND) ? sx[CW-1:0] : '0;
    assign bus.y_out    = (state == SEND) ? sy[CW-1:0] : '0;
    assign bus.is_out   = is_q;
    assign bus.busy     = (state != IDLE);
    assign bus.underrun = unr_q;
endmodule
